// File: rtl/dspl_pkg.sv
// Shared symbol codes, word packing helpers and FSM states for the Bulls & Cows
// display formatter.
package dspl_pkg;

  localparam logic [4:0] SYM_0     = 5'h00;
  localparam logic [4:0] SYM_1     = 5'h01;
  localparam logic [4:0] SYM_2     = 5'h02;
  localparam logic [4:0] SYM_3     = 5'h03;
  localparam logic [4:0] SYM_4     = 5'h04;
  localparam logic [4:0] SYM_J     = 5'h05;
  localparam logic [4:0] SYM_S     = 5'h06;
  localparam logic [4:0] SYM_E     = 5'h07;
  localparam logic [4:0] SYM_T     = 5'h08;
  localparam logic [4:0] SYM_U     = 5'h09;
  localparam logic [4:0] SYM_P     = 5'h0A;
  localparam logic [4:0] SYM_B     = 5'h0B;
  localparam logic [4:0] SYM_C     = 5'h0C;
  localparam logic [4:0] SYM_L     = 5'h0D;
  localparam logic [4:0] SYM_Y     = 5'h0E;
  localparam logic [4:0] SYM_G     = 5'h0F;
  localparam logic [4:0] SYM_BLANK = 5'h10;

  localparam logic [6:0] DSPL_OFF = 7'h21;

  typedef enum logic [2:0] {BLANK, SETUP, GUESS, RESULT, WIN} state_t;

  // Disabled words collapse to DSPL_OFF so the driver never sees a stray dp.
  function automatic logic [6:0] mk_word(input logic en, input logic [4:0] sym,
                                         input logic dp_on);
    return en ? {1'b1, sym, ~dp_on} : DSPL_OFF;
  endfunction

  function automatic logic [4:0] dig_sym(input logic [2:0] d);
    return (d > 3'd4) ? SYM_BLANK : {2'b00, d};
  endfunction

endpackage

// File: rtl/dspl_tick_gen.sv
// Tick prescaler with blink phase; restart re-aligns both to a fresh period.
module dspl_tick_gen #(
  parameter int TICK_COUNT = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic phase
);

  localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_COUNT - 1));

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dspl_fmt_bc.sv
// Bulls & Cows display formatter: maps game events to eight registered symbol
// words for the multiplexed display driver, with result hold and blink.
module dspl_fmt_bc
  import dspl_pkg::*;
#(
  parameter int TICK_COUNT   = 25000000,
  parameter int RESULT_TICKS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        setup_req,
  input  logic        player,
  input  logic        guess_req,
  input  logic        result_req,
  input  logic        win_req,
  input  logic [2:0]  entry_cnt,
  input  logic [11:0] entry_digits,
  input  logic [2:0]  bulls,
  input  logic [2:0]  cows,
  output logic        busy,
  output logic [6:0]  d1,
  output logic [6:0]  d2,
  output logic [6:0]  d3,
  output logic [6:0]  d4,
  output logic [6:0]  d5,
  output logic [6:0]  d6,
  output logic [6:0]  d7,
  output logic [6:0]  d8
);

  localparam int HW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;

  state_t          state, nxt;
  logic            enter, lat_player, lat_res;
  logic            tick, phase;
  logic [HW-1:0]   hold;
  logic            player_q;
  logic [2:0]      bulls_q, cows_q, ecnt;
  logic [7:0][6:0] scr, dq;

  dspl_tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (enter),
    .tick    (tick),
    .phase   (phase)
  );

  // Request arbitration; every accepted request counts as a state entry.
  always_comb begin
    nxt        = state;
    enter      = 1'b0;
    lat_player = 1'b0;
    lat_res    = 1'b0;
    if (win_req) begin
      nxt   = WIN;
      enter = 1'b1;
    end else if (result_req && state != WIN) begin
      nxt     = RESULT;
      enter   = 1'b1;
      lat_res = 1'b1;
    end else if (setup_req) begin
      nxt        = SETUP;
      enter      = 1'b1;
      lat_player = 1'b1;
    end else if (guess_req && (state == BLANK || state == SETUP || state == RESULT)) begin
      nxt   = GUESS;
      enter = 1'b1;
    end else if (state == RESULT && tick && hold == HW'(RESULT_TICKS - 1)) begin
      nxt   = GUESS;
      enter = 1'b1;
    end
  end

  always_comb begin
    scr  = {8{DSPL_OFF}};
    ecnt = (entry_cnt > 3'd4) ? 3'd4 : entry_cnt;
    case (state)
      SETUP: begin
        scr[7] = mk_word(1'b1, SYM_J, 1'b0);
        scr[6] = mk_word(1'b1, {4'b0, player_q} + 5'd1, 1'b0);
        scr[4] = mk_word(1'b1, SYM_S, 1'b0);
        scr[3] = mk_word(1'b1, SYM_E, 1'b0);
        scr[2] = mk_word(1'b1, SYM_T, 1'b0);
        scr[1] = mk_word(1'b1, SYM_U, 1'b0);
        scr[0] = mk_word(1'b1, SYM_P, 1'b0);
      end
      GUESS: begin
        scr[7] = mk_word(1'b1, SYM_J, 1'b0);
        scr[6] = mk_word(1'b1, {4'b0, player_q} + 5'd1, 1'b0);
        // First entered digit lands on d4; the cursor blinks via its dp.
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < ecnt)
            scr[3-i] = mk_word(1'b1, dig_sym(entry_digits[3*i +: 3]), 1'b0);
          else if (3'(i) == ecnt)
            scr[3-i] = mk_word(1'b1, SYM_BLANK, phase);
        end
      end
      RESULT: begin
        scr[7] = mk_word(1'b1, SYM_B, 1'b0);
        scr[6] = mk_word(1'b1, dig_sym(bulls_q), 1'b0);
        scr[4] = mk_word(1'b1, SYM_C, 1'b0);
        scr[3] = mk_word(1'b1, dig_sym(cows_q), 1'b0);
      end
      WIN: begin
        scr[7] = mk_word(phase, SYM_B, 1'b0);
        scr[6] = mk_word(phase, SYM_U, 1'b0);
        scr[5] = mk_word(phase, SYM_L, 1'b0);
        scr[4] = mk_word(phase, SYM_L, 1'b0);
        scr[3] = mk_word(phase, SYM_S, 1'b0);
        scr[2] = mk_word(phase, SYM_E, 1'b0);
        scr[1] = mk_word(phase, SYM_Y, 1'b0);
        scr[0] = mk_word(phase, SYM_E, 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BLANK;
      hold     <= '0;
      player_q <= 1'b0;
      bulls_q  <= '0;
      cows_q   <= '0;
      dq       <= {8{DSPL_OFF}};
      busy     <= 1'b0;
    end else begin
      state <= nxt;
      if (enter)
        hold <= '0;
      else if (tick && state == RESULT)
        hold <= hold + HW'(1);
      if (lat_player) player_q <= player;
      if (lat_res) begin
        bulls_q <= bulls;
        cows_q  <= cows;
      end
      dq   <= scr;
      busy <= (state == RESULT);
    end
  end

  assign {d8, d7, d6, d5, d4, d3, d2, d1} = dq;

endmodule

// File: tb/tb_dspl_fmt_bc.sv
// Directed bench for dspl_fmt_bc with a 4-cycle tick and 3-tick result hold.
module tb_dspl_fmt_bc;

  logic        clock = 1'b0;
  logic        reset, setup_req, player, guess_req, result_req, win_req;
  logic [2:0]  entry_cnt, bulls, cows;
  logic [11:0] entry_digits;
  logic        busy;
  logic [6:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0][6:0] scr;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OFF = 7'h21;
  localparam logic [6:0] W_J = 7'h4B, W_1 = 7'h43, W_2 = 7'h45, W_3 = 7'h47, W_4 = 7'h49;
  localparam logic [6:0] W_S = 7'h4D, W_E = 7'h4F, W_T = 7'h51, W_U = 7'h53, W_P = 7'h55;
  localparam logic [6:0] W_B = 7'h57, W_C = 7'h59, W_L = 7'h5B, W_Y = 7'h5D;
  localparam logic [6:0] BLK_DP = 7'h60, BLK = 7'h61;

  dspl_fmt_bc #(.TICK_COUNT(4), .RESULT_TICKS(3)) dut (
    .clock(clock), .reset(reset), .setup_req(setup_req), .player(player),
    .guess_req(guess_req), .result_req(result_req), .win_req(win_req),
    .entry_cnt(entry_cnt), .entry_digits(entry_digits), .bulls(bulls), .cows(cows),
    .busy(busy), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  always #5 clock = ~clock;
  assign scr = {d8, d7, d6, d5, d4, d3, d2, d1};

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // exp[7] is d8 (leftmost), exp[0] is d1.
  task automatic chk_scr(input string tag, input logic [7:0][6:0] exp);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_d%0d", tag, i + 1), scr[i], exp[i]);
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    chk(tag, {6'b0, busy}, {6'b0, exp});
  endtask

  initial begin
    int n;
    reset = 1'b1; setup_req = 0; player = 0; guess_req = 0; result_req = 0; win_req = 0;
    entry_cnt = 0; entry_digits = 0; bulls = 0; cows = 0;
    step(3);
    chk_scr("rst", {8{OFF}});
    chk_busy("rst_busy", 1'b0);
    reset = 1'b0;
    step(2);
    chk_scr("idle", {8{OFF}});

    player = 1'b1; setup_req = 1'b1; step; setup_req = 1'b0; step;
    chk_scr("setup", {W_J, W_2, OFF, W_S, W_E, W_T, W_U, W_P});

    entry_cnt = 3'd2; entry_digits = {3'd0, 3'd0, 3'd1, 3'd3};
    guess_req = 1'b1; step; guess_req = 1'b0; step;
    chk_scr("guess_dp1", {W_J, W_2, OFF, OFF, W_3, W_1, BLK_DP, OFF});
    step(4);
    chk("guess_dp0", d2, BLK);
    step(4);
    chk("guess_dp1b", d2, BLK_DP);

    entry_cnt = 3'd7; entry_digits = {3'd4, 3'd7, 3'd1, 3'd3};
    step;
    chk_scr("guess_clamp", {W_J, W_2, OFF, OFF, W_3, W_1, BLK, W_4});
    entry_cnt = 3'd2; entry_digits = {3'd0, 3'd0, 3'd1, 3'd3};

    bulls = 3'd2; cows = 3'd1;
    result_req = 1'b1; step; result_req = 1'b0; step;
    chk_scr("result", {W_B, W_2, OFF, W_C, W_1, OFF, OFF, OFF});
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step;
    end
    chk("busy_len", 7'(n), 7'd12);
    chk_busy("busy_drop", 1'b0);
    chk_scr("guess_back", {W_J, W_2, OFF, OFF, W_3, W_1, BLK_DP, OFF});

    bulls = 3'd6;
    result_req = 1'b1; step; result_req = 1'b0; step;
    chk("bulls6", d7, BLK);
    chk_busy("busy6", 1'b1);

    result_req = 1'b1; win_req = 1'b1; step; result_req = 1'b0; win_req = 1'b0; step;
    chk_scr("win_on", {W_B, W_U, W_L, W_L, W_S, W_E, W_Y, W_E});
    chk_busy("win_busy", 1'b0);
    step(4);
    chk_scr("win_off", {8{OFF}});
    step(4);
    chk_scr("win_on2", {W_B, W_U, W_L, W_L, W_S, W_E, W_Y, W_E});
    result_req = 1'b1; step; result_req = 1'b0; step;
    chk("win_ign_d8", d8, W_B);
    chk_busy("win_ign_busy", 1'b0);

    player = 1'b0; setup_req = 1'b1; step; setup_req = 1'b0; step;
    chk_scr("setup_j1", {W_J, W_1, OFF, W_S, W_E, W_T, W_U, W_P});

    bulls = 3'd2;
    result_req = 1'b1; step; result_req = 1'b0; step(3);
    chk_busy("hold_mid", 1'b1);
    reset = 1'b1; step;
    chk_scr("rst_hold", {8{OFF}});
    chk_busy("rst_hold_busy", 1'b0);
    reset = 1'b0; step(2);
    chk_scr("blank_after", {8{OFF}});
    chk_busy("blank_busy", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
